control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Harness/datapath-facing signal bundle of the control sequencer.
// The sequencer uses the master side; the datapath and test harness use the slave side.
interface control_sequencer_if;
  logic        Run;
  logic [31:0] IR;
  logic        PCout;
  logic        MARin;
  logic        IncPC;
  logic        Zin;
  logic        ZLOout;
  logic        PCin;
  logic        Read;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  ALUSelection;
  logic        Busy;
  logic        Halted;
  logic [15:0] RetireCount;

  modport master (
    input  Run, IR,
    output PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin,
    output Rin, Rout, ALUSelection, Busy, Halted, RetireCount
  );

  modport slave (
    output Run, IR,
    input  PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin,
    input  Rin, Rout, ALUSelection, Busy, Halted, RetireCount
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: three fetch steps, up to three execute
// steps for ALU-class instructions, and a sticky HALT state left only via clr.
module control_sequencer #(
  parameter logic [15:0] RETIRE_INIT = '0
) (
  input  logic                 clk,
  input  logic                 clr,
  control_sequencer_if.master  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_retire;

  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_alu_class;
  logic        w_halt_op;
  logic        w_unused_ir;

  logic        w_pcout, w_marin, w_incpc, w_zin, w_zloout, w_pcin;
  logic        w_read, w_mdrin, w_mdrout, w_irin, w_yin;
  logic [15:0] w_rin;
  logic [15:0] w_rout;
  logic [4:0]  w_alusel;

  assign w_op        = bus.IR[31:27];
  assign w_ra        = bus.IR[26:23];
  assign w_rb        = bus.IR[22:19];
  assign w_rc        = bus.IR[18:15];
  assign w_alu_class = (w_op <= 5'd12);
  assign w_halt_op   = (w_op == 5'b11011);
  assign w_unused_ir = ^bus.IR[14:0];

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = bus.Run ? S_T0 : S_IDLE;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3: begin
        if (w_alu_class)    w_next = S_T4;
        else if (w_halt_op) w_next = S_HALT;
        else                w_next = bus.Run ? S_T0 : S_IDLE;
      end
      S_T4:   w_next = S_T5;
      S_T5:   w_next = bus.Run ? S_T0 : S_IDLE;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_retire <= RETIRE_INIT;
    end else begin
      r_state <= w_next;
      if (r_state == S_T5) r_retire <= r_retire + 16'd1;
    end
  end

  // Moore decode: register selects come from IR only in T3..T5, after IRin has loaded it.
  always_comb begin
    w_pcout  = 1'b0;
    w_marin  = 1'b0;
    w_incpc  = 1'b0;
    w_zin    = 1'b0;
    w_zloout = 1'b0;
    w_pcin   = 1'b0;
    w_read   = 1'b0;
    w_mdrin  = 1'b0;
    w_mdrout = 1'b0;
    w_irin   = 1'b0;
    w_yin    = 1'b0;
    w_rin    = '0;
    w_rout   = '0;
    w_alusel = '0;
    case (r_state)
      S_T0: begin
        w_pcout = 1'b1;
        w_marin = 1'b1;
        w_incpc = 1'b1;
        w_zin   = 1'b1;
      end
      S_T1: begin
        w_zloout = 1'b1;
        w_pcin   = 1'b1;
        w_read   = 1'b1;
        w_mdrin  = 1'b1;
      end
      S_T2: begin
        w_mdrout = 1'b1;
        w_irin   = 1'b1;
      end
      S_T3: begin
        if (w_alu_class) begin
          w_rout = 16'h0001 << w_rb;
          w_yin  = 1'b1;
        end
      end
      S_T4: begin
        w_rout   = 16'h0001 << w_rc;
        w_zin    = 1'b1;
        w_alusel = w_op;
      end
      S_T5: begin
        w_zloout = 1'b1;
        w_rin    = 16'h0001 << w_ra;
      end
      default: ;
    endcase
  end

  assign bus.PCout        = w_pcout;
  assign bus.MARin        = w_marin;
  assign bus.IncPC        = w_incpc;
  assign bus.Zin          = w_zin;
  assign bus.ZLOout       = w_zloout;
  assign bus.PCin         = w_pcin;
  assign bus.Read         = w_read;
  assign bus.MDRin        = w_mdrin;
  assign bus.MDRout       = w_mdrout;
  assign bus.IRin         = w_irin;
  assign bus.Yin          = w_yin;
  assign bus.Rin          = w_rin;
  assign bus.Rout         = w_rout;
  assign bus.ALUSelection = w_alusel;
  assign bus.Busy         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.Halted       = (r_state == S_HALT);
  assign bus.RetireCount  = r_retire;

endmodule
